banked_mem_ctrl: RTL

Next-generation banked scratchpad for the DAG processor datapath. It replaces the shared-address memory with N_BANKS banks that each have their own address, byte-enable writes, and a flowing read pipeline that emits rd_valid. It adds a hardware clear engine that runs after reset or on request, and sticky detection of same-bank read/write collisions. It sits between the PE-array load/store units and storage; storage is a functional array.

---
 rtl/mem_pkg.sv | 18 +
 rtl/banked_mem_ctrl_if.sv | 39 +++
 rtl/bank_sp_mem.sv | 67 ++++++
 rtl/banked_mem_ctrl.sv | 131 +++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// ============================================================================
// Module   : mem_pkg
// Desc     : Shared constants and state encoding for the banked scratchpad.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_pkg;
  localparam logic RESET_STATE = 1'b0;
  localparam int   BYTE_L      = 8;

  typedef enum logic [0:0] {
    S_CLEAR = 1'b0,
    S_READY = 1'b1
  } mem_state_t;
endpackage

`default_nettype wire

// File: rtl/banked_mem_ctrl_if.sv
// ============================================================================
// Module   : banked_mem_ctrl_if
// Desc     : Per-bank request/response bundle between load/store units and memory.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface banked_mem_ctrl_if
  import mem_pkg::*;
#(
  parameter int N_BANKS = 8,
  parameter int ADDR_L  = 10,
  parameter int DATA_L  = 32
) ();
  logic                                    clear_req;
  logic                                    busy;
  logic                                    req_ready;
  logic [N_BANKS-1:0][ADDR_L-1:0]          addr;
  logic [N_BANKS-1:0]                      wr_en;
  logic [N_BANKS-1:0][DATA_L/BYTE_L-1:0]   wr_be;
  logic [N_BANKS-1:0][DATA_L-1:0]          wr_data;
  logic [N_BANKS-1:0]                      rd_en;
  logic [N_BANKS-1:0][DATA_L-1:0]          rd_data;
  logic [N_BANKS-1:0]                      rd_valid;
  logic [N_BANKS-1:0]                      err_collision;
  logic                                    err_clr;

  modport master (
    output clear_req, addr, wr_en, wr_be, wr_data, rd_en, err_clr,
    input  busy, req_ready, rd_data, rd_valid, err_collision
  );

  modport slave (
    input  clear_req, addr, wr_en, wr_be, wr_data, rd_en, err_clr,
    output busy, req_ready, rd_data, rd_valid, err_collision
  );
endinterface

`default_nettype wire

// File: rtl/bank_sp_mem.sv
// ============================================================================
// Module   : bank_sp_mem
// Desc     : One byte-writable storage bank with a fixed-latency read pipeline.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bank_sp_mem
  import mem_pkg::*;
#(
  parameter int DATA_L     = 32,
  parameter int ADDR_L     = 10,
  parameter int RD_LATENCY = 2
) (
  input  wire logic                       clk,
  input  wire logic                       rst,
  input  wire logic                       wr_en,
  input  wire logic                       rd_en,
  input  wire logic [DATA_L/BYTE_L-1:0]   be,
  input  wire logic [ADDR_L-1:0]          addr,
  input  wire logic [DATA_L-1:0]          wr_data,
  output logic      [DATA_L-1:0]          rd_data,
  output logic                            rd_valid
);
  localparam int c_n_bytes = DATA_L / BYTE_L;
  localparam int c_depth   = 2 ** ADDR_L;

  logic [DATA_L-1:0]     r_mem [c_depth];
  logic [RD_LATENCY-1:0] r_vld;
  logic [DATA_L-1:0]     r_dat [RD_LATENCY];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < c_n_bytes; i++) begin
        if (be[i]) begin
          r_mem[addr][i*BYTE_L +: BYTE_L] <= wr_data[i*BYTE_L +: BYTE_L];
        end
      end
    end
  end

  // Data only advances alongside a valid token, so the last stage holds its value between reads.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RESET_STATE) begin
      r_vld <= '0;
      for (int k = 0; k < RD_LATENCY; k++) begin
        r_dat[k] <= '0;
      end
    end else begin
      r_vld[0] <= rd_en;
      if (rd_en) begin
        r_dat[0] <= r_mem[addr];
      end
      for (int k = 1; k < RD_LATENCY; k++) begin
        r_vld[k] <= r_vld[k-1];
        if (r_vld[k-1]) begin
          r_dat[k] <= r_dat[k-1];
        end
      end
    end
  end

  assign rd_data  = r_dat[RD_LATENCY-1];
  assign rd_valid = r_vld[RD_LATENCY-1];
endmodule

`default_nettype wire

// File: rtl/banked_mem_ctrl.sv
// ============================================================================
// Module   : banked_mem_ctrl
// Desc     : Banked scratchpad with clear engine and sticky collision flags.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module banked_mem_ctrl
  import mem_pkg::*;
#(
  parameter int DATA_L         = 32,
  parameter int ADDR_L         = 10,
  parameter int N_BANKS        = 8,
  parameter int RD_LATENCY     = 2,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input wire logic         clk,
  input wire logic         rst,
  banked_mem_ctrl_if.slave bus
);
  localparam int                c_n_bytes   = DATA_L / BYTE_L;
  localparam logic [ADDR_L-1:0] c_last_addr = '1;

  generate
    if (DATA_L % BYTE_L != 0) begin : g_chk_data
      $fatal(1, "DATA_L must be a multiple of 8");
    end
    if (RD_LATENCY < 1) begin : g_chk_lat
      $fatal(1, "RD_LATENCY must be >= 1");
    end
    if (ADDR_L < 1) begin : g_chk_addr
      $fatal(1, "ADDR_L must be >= 1");
    end
    if (N_BANKS < 1) begin : g_chk_banks
      $fatal(1, "N_BANKS must be >= 1");
    end
  endgenerate

  mem_state_t                      r_state;
  mem_state_t                      w_state_nxt;
  logic [ADDR_L-1:0]               r_clr_cnt;
  logic [ADDR_L-1:0]               w_clr_cnt_nxt;
  logic                            w_busy;
  logic [N_BANKS-1:0]              w_err_set;
  logic [N_BANKS-1:0]              r_err;
  logic [N_BANKS-1:0][DATA_L-1:0]  w_rd_data;
  logic [N_BANKS-1:0]              w_rd_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RESET_STATE) begin
      r_state   <= CLEAR_ON_RESET ? S_CLEAR : S_READY;
      r_clr_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_cnt <= w_clr_cnt_nxt;
    end
  end

  // The counter wraps to zero on the final clear write, ready for the next request.
  always_comb begin
    w_state_nxt   = r_state;
    w_clr_cnt_nxt = r_clr_cnt;
    case (r_state)
      S_CLEAR: begin
        w_clr_cnt_nxt = r_clr_cnt + 1'b1;
        if (r_clr_cnt == c_last_addr) begin
          w_state_nxt = S_READY;
        end
      end
      S_READY: begin
        if (bus.clear_req) begin
          w_state_nxt   = S_CLEAR;
          w_clr_cnt_nxt = '0;
        end
      end
      default: w_state_nxt = S_READY;
    endcase
  end

  assign w_busy = (r_state == S_CLEAR);

  generate
    for (genvar b = 0; b < N_BANKS; b++) begin : g_bank
      logic                 w_wr;
      logic                 w_rd;
      logic [c_n_bytes-1:0] w_be;
      logic [ADDR_L-1:0]    w_addr;
      logic [DATA_L-1:0]    w_wdata;

      // A colliding read is dropped; the write still goes through.
      assign w_wr         = w_busy | bus.wr_en[b];
      assign w_rd         = ~w_busy & bus.rd_en[b] & ~bus.wr_en[b];
      assign w_be         = w_busy ? '1 : bus.wr_be[b];
      assign w_addr       = w_busy ? r_clr_cnt : bus.addr[b];
      assign w_wdata      = w_busy ? '0 : bus.wr_data[b];
      assign w_err_set[b] = ~w_busy & bus.wr_en[b] & bus.rd_en[b];

      bank_sp_mem #(
        .DATA_L     (DATA_L),
        .ADDR_L     (ADDR_L),
        .RD_LATENCY (RD_LATENCY)
      ) u_bank (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (w_wr),
        .rd_en    (w_rd),
        .be       (w_be),
        .addr     (w_addr),
        .wr_data  (w_wdata),
        .rd_data  (w_rd_data[b]),
        .rd_valid (w_rd_valid[b])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RESET_STATE) begin
      r_err <= '0;
    end else begin
      r_err <= w_err_set | (r_err & ~{N_BANKS{bus.err_clr}});
    end
  end

  assign bus.busy          = w_busy;
  assign bus.req_ready     = ~w_busy;
  assign bus.rd_data       = w_rd_data;
  assign bus.rd_valid      = w_rd_valid;
  assign bus.err_collision = r_err;
endmodule

`default_nettype wire
